// File: rtl/dt_walker_pkg.sv
// Shared definitions for the table-driven decision-tree walker: node-word layout,
// FSM encodings and a node packing helper.
package dt_walker_pkg;

   localparam int NODES_DEF = 32;
   localparam int AW_DEF    = 5;
   localparam int FEAT_W    = 3;
   localparam int WORD_W    = 4 + 2 * AW_DEF;

   // Node word, MSB first: leaf, feat[2:0], fchild[aw-1:0], tchild[aw-1:0]
   function automatic int tchild_lsb(input int aw);
      return 0;
   endfunction

   function automatic int fchild_lsb(input int aw);
      return aw;
   endfunction

   function automatic int feat_lsb(input int aw);
      return 2 * aw;
   endfunction

   function automatic int leaf_bit(input int aw);
      return 2 * aw + 3;
   endfunction

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WALK = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef logic [WORD_W-1:0] node_word_t;

   localparam node_word_t LEAF_RESET = {1'b1, {(WORD_W-1){1'b0}}};

   function automatic node_word_t pack_node(input logic              leaf,
                                            input logic [FEAT_W-1:0] feat,
                                            input logic [AW_DEF-1:0] fchild,
                                            input logic [AW_DEF-1:0] tchild);
      return {leaf, feat, fchild, tchild};
   endfunction

endpackage

// File: rtl/dt_node_table.sv
// Flop-based node table: one synchronous write port, one combinational read port,
// every entry returns to RESET_WORD on reset.
module dt_node_table #(
   parameter int              NODES      = 32,
   parameter int              AW         = 5,
   parameter int              WW         = 14,
   parameter logic [WW-1:0]   RESET_WORD = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [WW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [WW-1:0] rdata
);

   logic [WW-1:0] mem [NODES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NODES; i++) begin
            mem[i] <= RESET_WORD;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/dt_table_walker.sv
// Reprogrammable decision-tree classifier: walks the node table one node per clock
// for each accepted 8-bit sample and returns class, depth and a depth-guard flag.
module dt_table_walker
   import dt_walker_pkg::*;
#(
   parameter int NODES     = 32,
   parameter int AW        = $clog2(NODES),
   parameter int MAX_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cfg_we,
   input  logic [AW-1:0]                  cfg_addr,
   input  logic [4+2*AW-1:0]              cfg_wdata,
   output logic                           cfg_err,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [7:0]                     in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [1:0]                     out_class,
   output logic [$clog2(MAX_DEPTH+1)-1:0] out_depth,
   output logic                           out_err
);

   localparam int WW       = 4 + 2 * AW;
   localparam int DW       = $clog2(MAX_DEPTH + 1);
   localparam int LEAF_B   = leaf_bit(AW);
   localparam int FEAT_LSB = feat_lsb(AW);
   localparam int FCH_LSB  = fchild_lsb(AW);
   localparam int TCH_LSB  = tchild_lsb(AW);

   logic [1:0]        state;
   logic [7:0]        sample;
   logic [AW-1:0]     cur;
   logic [DW-1:0]     depth;
   logic [WW-1:0]     node;
   logic [FEAT_W-1:0] feat;
   logic [AW-1:0]     next_child;
   logic              is_leaf;
   logic              table_we;

   // Writes outside IDLE are dropped so the table never changes under a walk.
   assign table_we = cfg_we && (state == ST_IDLE);

   dt_node_table #(
      .NODES      (NODES),
      .AW         (AW),
      .WW         (WW),
      .RESET_WORD ({1'b1, {(WW-1){1'b0}}})
   ) u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (table_we),
      .waddr (cfg_addr),
      .wdata (cfg_wdata),
      .raddr (cur),
      .rdata (node)
   );

   assign is_leaf    = node[LEAF_B];
   assign feat       = node[FEAT_LSB +: FEAT_W];
   assign next_child = sample[feat] ? node[TCH_LSB +: AW] : node[FCH_LSB +: AW];

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         sample    <= '0;
         cur       <= '0;
         depth     <= '0;
         out_class <= '0;
         out_depth <= '0;
         out_err   <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= cfg_we && (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sample <= in_data;
                  cur    <= '0;
                  depth  <= '0;
                  state  <= ST_WALK;
               end
            end
            ST_WALK: begin
               if (is_leaf) begin
                  out_class <= node[1:0];
                  out_depth <= depth;
                  out_err   <= 1'b0;
                  state     <= ST_DONE;
               end else if (depth == DW'(MAX_DEPTH)) begin
                  out_class <= 2'b00;
                  out_depth <= DW'(MAX_DEPTH);
                  out_err   <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  cur   <= next_child;
                  depth <= depth + DW'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dt_table_walker.sv
// Directed bench for dt_table_walker: expected results queued at sample acceptance
// and compared when the result handshake completes.
module tb_dt_table_walker;
   import dt_walker_pkg::*;

   localparam int AW = 5;
   localparam int DW = 4;
   localparam int WW = 4 + 2 * AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [WW-1:0] cfg_wdata;
   logic          cfg_err;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out_class;
   logic [DW-1:0] out_depth;
   logic          out_err;

   int checks = 0;
   int errors = 0;
   // {class[1:0], depth[3:0], err}
   logic [6:0] exp_q[$];

   dt_table_walker #(.NODES(32), .AW(AW), .MAX_DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_err   (cfg_err),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_depth (out_depth),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: pop on every completed result handshake.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'd1, 32'd0);
         end else begin
            logic [6:0] e;
            e = exp_q.pop_front();
            check("out_class", 32'(out_class), 32'(e[6:5]));
            check("out_depth", 32'(out_depth), 32'(e[4:1]));
            check("out_err",   32'(out_err),   32'(e[0]));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic write_node(input logic [AW-1:0] addr, input logic [WW-1:0] word);
      cfg_addr  = addr;
      cfg_wdata = word;
      cfg_we    = 1'b1;
      @(posedge clk); #1;
      cfg_we    = 1'b0;
   endtask

   task automatic program_tree();
      write_node(5'd0, pack_node(1'b0, 3'd6, 5'd1, 5'd2));
      write_node(5'd1, pack_node(1'b1, 3'd0, 5'd0, 5'd2));
      write_node(5'd2, pack_node(1'b0, 3'd7, 5'd3, 5'd4));
      write_node(5'd3, pack_node(1'b1, 3'd0, 5'd0, 5'd1));
      write_node(5'd4, pack_node(1'b1, 3'd0, 5'd0, 5'd0));
   endtask

   task automatic accept(input logic [7:0] data, input logic [6:0] exp);
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("accept_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = data;
      exp_q.push_back(exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
   endtask

   // Counts cycles after the acceptance edge until out_valid; expected is depth+1.
   task automatic wait_valid(input string tag, input int exp_lat);
      int cnt = 0;
      @(negedge clk);
      while (!out_valid && cnt < 40) begin
         @(negedge clk);
         cnt++;
      end
      check(tag, 32'(cnt), 32'(exp_lat));
      @(posedge clk); #1;
   endtask

   initial begin
      logic [WW-1:0] lr;
      logic          seen;
      int            n;
      lr        = LEAF_RESET;
      rst       = 1'b1;
      cfg_we    = 1'b0;
      cfg_addr  = '0;
      cfg_wdata = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_class", 32'(out_class), 32'd0);
      check("rst_out_depth", 32'(out_depth), 32'd0);
      check("rst_out_err",   32'(out_err),   32'd0);
      check("rst_cfg_err",   32'(cfg_err),   32'd0);
      @(posedge clk); #1;

      program_tree();

      // Single internal node then leaf class 10; valid exactly one cycle.
      accept(8'h00, {2'b10, 4'd1, 1'b0});
      wait_valid("s1_latency", 2);
      @(negedge clk);
      check("s1_one_cycle", 32'(out_valid), 32'd0);
      @(posedge clk); #1;

      accept(8'hC0, {2'b00, 4'd2, 1'b0});
      wait_valid("s2a_latency", 3);
      accept(8'h40, {2'b01, 4'd2, 1'b0});
      wait_valid("s2b_latency", 3);

      // Back-pressure hold.
      out_ready = 1'b0;
      accept(8'h00, {2'b10, 4'd1, 1'b0});
      wait_valid("s3_latency", 2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("s3_hold_valid", 32'(out_valid), 32'd1);
         check("s3_hold_class", 32'(out_class), 32'd2);
         check("s3_hold_depth", 32'(out_depth), 32'd1);
         check("s3_hold_ready", 32'(in_ready),  32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check("s3_release_valid", 32'(out_valid), 32'd0);
      check("s3_release_ready", 32'(in_ready),  32'd1);
      @(posedge clk); #1;

      // Write during WALK is dropped with a one-cycle cfg_err.
      accept(8'hC0, {2'b00, 4'd2, 1'b0});
      cfg_addr  = 5'd4;
      cfg_wdata = pack_node(1'b1, 3'd0, 5'd0, 5'd3);
      cfg_we    = 1'b1;
      @(posedge clk); #1;
      cfg_we    = 1'b0;
      @(negedge clk);
      check("s5_cfg_err_pulse", 32'(cfg_err), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check("s5_cfg_err_clear", 32'(cfg_err), 32'd0);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("s5_walk_done", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
      accept(8'hC0, {2'b00, 4'd2, 1'b0});
      wait_valid("s5_unchanged_latency", 3);

      // Write in the acceptance cycle is seen by that walk.
      cfg_addr  = 5'd4;
      cfg_wdata = pack_node(1'b1, 3'd0, 5'd0, 5'd3);
      cfg_we    = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'hC0;
      exp_q.push_back({2'b11, 4'd2, 1'b0});
      @(posedge clk); #1;
      cfg_we    = 1'b0;
      in_valid  = 1'b0;
      wait_valid("s5_same_cycle_latency", 3);

      // Self-loop trips the depth guard.
      write_node(5'd0, pack_node(1'b0, 3'd0, 5'd0, 5'd0));
      accept(8'($urandom_range(0, 255)), {2'b00, 4'd8, 1'b1});
      wait_valid("s4_loop_latency", 9);

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      accept(8'($urandom_range(0, 255)), {lr[1:0], 4'd0, 1'b0});
      wait_valid("s4_reset_table_latency", 1);

      // Reset mid-walk drops the sample and restores the table.
      program_tree();
      accept(8'hC0, {2'b00, 4'd2, 1'b0});
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("s6_no_valid", 32'(seen), 32'd0);
      check("s6_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      accept(8'hC0, {lr[1:0], 4'd0, 1'b0});
      wait_valid("s6_after_reset_latency", 1);

      repeat (2) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
